mult_div_unit: RTL and testbench

//  Execute-stage multiply/divide unit with HI/LO registers. Consumes the start strobe,
//  op and forwarded rs/rt operands delivered by the ID/EX pipeline register.

---
 rtl/md_pkg.sv | 28 ++
 rtl/md_result_calc.sv | 58 +++++
 rtl/mult_div_unit.sv | 101 ++++++++++
 tb/tb_mult_div_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md_pkg
// Purpose  : Shared encodings and defaults for the execute-stage mult/div unit.
// Revision : 1.0 - initial release
// ============================================================================
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Ops 0..3 are the multi-cycle arithmetic ops
  function automatic logic is_long_op(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_result_calc.sv
`default_nettype none
// ============================================================================
// Module   : md_result_calc
// Purpose  : Combinational {hi,lo} result and zero-divisor flag for MULT/DIV ops.
// Revision : 1.0 - initial release
// ============================================================================
module md_result_calc
  import md_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q;
  logic [31:0] w_r;

  assign w_prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Sign-magnitude divide: 0x80000000 / -1 naturally yields 0x80000000 rem 0
  assign w_signed = (md_op == MD_DIV);
  assign w_a_neg  = w_signed & rs_val[31];
  assign w_b_neg  = w_signed & rt_val[31];
  assign w_a_mag  = w_a_neg ? (32'd0 - rs_val) : rs_val;
  assign w_b_mag  = w_b_neg ? (32'd0 - rt_val) : rt_val;
  assign w_b_safe = (rt_val == 32'd0) ? 32'd1 : w_b_mag;
  assign w_q_mag  = w_a_mag / w_b_safe;
  assign w_r_mag  = w_a_mag % w_b_safe;
  assign w_q      = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_r      = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

  assign div_by_zero = ((md_op == MD_DIV) || (md_op == MD_DIVU)) && (rt_val == 32'd0);

  always_comb begin
    result = 64'd0;
    case (md_op)
      MD_MULT:         result = w_prod_s;
      MD_MULTU:        result = w_prod_u;
      MD_DIV, MD_DIVU: result = {w_r, w_q};
      default:         result = 64'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Fixed-latency multiply/divide unit with HI/LO registers.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_CNT_W      = $clog2(c_MAX_CYCLES) + 1;

  logic [0:0]         r_state;
  logic [0:0]         w_next_state;
  logic [c_CNT_W-1:0] r_count;
  logic [63:0]        r_staged;
  logic               r_staged_dbz;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [63:0]        w_result;
  logic               w_dbz;
  logic               w_idle_start;
  logic               w_accept;
  logic               w_commit;

  md_result_calc u_calc (
    .md_op       (md_op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .result      (w_result),
    .div_by_zero (w_dbz)
  );

  assign w_idle_start = (r_state == ST_IDLE) && start;
  assign w_accept     = w_idle_start && is_long_op(md_op);
  assign w_commit     = (r_state == ST_RUN) && (r_count == c_CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = ST_RUN;
      ST_RUN:  if (w_commit) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count      <= '0;
      r_staged     <= 64'd0;
      r_staged_dbz <= 1'b0;
      r_hi         <= 32'd0;
      r_lo         <= 32'd0;
    end else begin
      if (w_accept) begin
        r_staged     <= w_result;
        r_staged_dbz <= w_dbz;
        r_count      <= md_op[1] ? c_CNT_W'(DIV_CYCLES) : c_CNT_W'(MULT_CYCLES);
      end else if (r_state == ST_RUN) begin
        r_count <= r_count - c_CNT_W'(1);
      end

      // A zero divisor still costs the full latency but leaves HI/LO untouched
      if (w_commit && !r_staged_dbz) begin
        r_hi <= r_staged[63:32];
        r_lo <= r_staged[31:0];
      end

      if (w_idle_start && (md_op == MD_MTHI)) r_hi <= rs_val;
      if (w_idle_start && (md_op == MD_MTLO)) r_lo <= rs_val;
    end
  end

  assign hi_out = r_hi;
  assign lo_out = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Purpose  : Self-checking bench for mult_div_unit against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  localparam int c_MULT_N = 5;
  localparam int c_DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mult_div_unit #(.MULT_CYCLES(c_MULT_N), .DIV_CYCLES(c_DIV_N)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  always #5 clk = ~clk;

  // Architectural effect of an op on HI/LO, using 64-bit host arithmetic
  task automatic model_exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd1: begin p = 64'(a) * 64'(b); m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      3'd3: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  function automatic int latency(input logic [2:0] op);
    return (op < 3'd2) ? c_MULT_N : c_DIV_N;
  endfunction

  // Issue one long op and count busy cycles; flags any HI/LO change while busy
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n, output bit early);
    logic [31:0] pre_hi, pre_lo;
    pre_hi = hi_out; pre_lo = lo_out;
    n = 0; early = 1'b0;
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
    while (busy && n < 64) begin
      n++;
      if (hi_out !== pre_hi || lo_out !== pre_lo) early = 1'b1;
      @(posedge clk); #1;
    end
    model_exec(op, a, b);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; md_op = 3'd4; rs_val = 32'hFFFF_FFFF; rt_val = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (hi_out !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi_out); end
    checks++; if (lo_out !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo_out); end
    start = 1'b0; reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic test_mult;
    int n; bit early;
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, n, early);
    checks++; if (n !== c_MULT_N) begin errors++; $display("FAIL mult_busy: got %0d want %0d", n, c_MULT_N); end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL mult_early: got %b want 0", early); end
    checks++; if ({hi_out, lo_out} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
      errors++; $display("FAIL mult_res: got %h_%h want ffffffff_fffffffa", hi_out, lo_out); end
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, n, early);
    checks++; if ({hi_out, lo_out} !== 64'h0000_0002_FFFF_FFFA) begin
      errors++; $display("FAIL multu_res: got %h_%h want 00000002_fffffffa", hi_out, lo_out); end
  endtask

  task automatic test_div;
    int n; bit early;
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, n, early);
    checks++; if (n !== c_DIV_N) begin errors++; $display("FAIL div_busy: got %0d want %0d", n, c_DIV_N); end
    checks++; if ({hi_out, lo_out} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++; $display("FAIL div_neg: got %h_%h want ffffffff_fffffffd", hi_out, lo_out); end
    run_op(3'd3, 32'd7, 32'd2, n, early);
    checks++; if ({hi_out, lo_out} !== 64'h0000_0001_0000_0003) begin
      errors++; $display("FAIL divu: got %h_%h want 00000001_00000003", hi_out, lo_out); end
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n, early);
    checks++; if ({hi_out, lo_out} !== 64'h0000_0000_8000_0000) begin
      errors++; $display("FAIL div_ovf: got %h_%h want 00000000_80000000", hi_out, lo_out); end
  endtask

  task automatic test_mt_divzero;
    int n; bit early;
    start = 1'b1; md_op = 3'd4; rs_val = 32'h1234_5678;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || hi_out !== 32'h1234_5678) begin
      errors++; $display("FAIL mthi: got busy=%b hi=%h want busy=0 hi=12345678", busy, hi_out); end
    md_op = 3'd5; rs_val = 32'hCAFE_BABE;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b0 || lo_out !== 32'hCAFE_BABE) begin
      errors++; $display("FAIL mtlo: got busy=%b lo=%h want busy=0 lo=cafebabe", busy, lo_out); end
    m_hi = 32'h1234_5678; m_lo = 32'hCAFE_BABE;
    run_op(3'd3, 32'd99, 32'd0, n, early);
    checks++; if (n !== c_DIV_N) begin errors++; $display("FAIL divz_busy: got %0d want %0d", n, c_DIV_N); end
    checks++; if ({hi_out, lo_out} !== 64'h1234_5678_CAFE_BABE) begin
      errors++; $display("FAIL divz_keep: got %h_%h want 12345678_cafebabe", hi_out, lo_out); end
  endtask

  task automatic test_busy_ignore;
    int n;
    start = 1'b1; md_op = 3'd0; rs_val = 32'd3; rt_val = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    n = busy ? 1 : 0;
    @(posedge clk); #1;
    if (busy) n++;
    start = 1'b1; md_op = 3'd5; rs_val = 32'h0000_DEAD;
    @(posedge clk); #1;
    if (busy) n++;
    md_op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    while (busy && n < 64) begin
      n++;
      @(posedge clk); #1;
    end
    model_exec(3'd0, 32'd3, 32'd4);
    checks++; if (n !== c_MULT_N) begin errors++; $display("FAIL ignore_busy: got %0d want %0d", n, c_MULT_N); end
    checks++; if (hi_out !== 32'd0 || lo_out !== 32'd12) begin
      errors++; $display("FAIL ignore_res: got %h_%h want 00000000_0000000c", hi_out, lo_out); end
    repeat (c_DIV_N + 2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || lo_out !== 32'd12) begin
      errors++; $display("FAIL ignore_late: got busy=%b lo=%h want busy=0 lo=0000000c", busy, lo_out); end
  endtask

  task automatic test_reset_mid;
    bit bad;
    start = 1'b1; md_op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    checks++; if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
      errors++; $display("FAIL rstmid: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi_out, lo_out); end
    bad = 1'b0;
    repeat (c_DIV_N + 2) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rstmid_late: got late activity=%b want 0", bad); end
  endtask

  task automatic test_random;
    int n; bit early;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        default: b = $urandom;
      endcase
      if (op < 3'd4) begin
        run_op(op, a, b, n, early);
        checks++; if (n !== latency(op) || early !== 1'b0) begin
          errors++; $display("FAIL rnd_busy op=%0d: got n=%0d early=%b want n=%0d early=0", op, n, early, latency(op)); end
      end else begin
        start = 1'b1; md_op = op; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        start = 1'b0;
        model_exec(op, a, b);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_mt_busy op=%0d: got %b want 0", op, busy); end
      end
      checks++; if (hi_out !== m_hi || lo_out !== m_lo) begin
        errors++; $display("FAIL rnd_res op=%0d a=%h b=%h: got %h_%h want %h_%h", op, a, b, hi_out, lo_out, m_hi, m_lo); end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 3'd0; rs_val = 32'd0; rt_val = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    test_reset;
    test_mult;
    test_div;
    test_mt_divzero;
    test_busy_ignore;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
